// File: rtl/c432_irq_dispatch.sv
// ============================================================================
// Module   : c432_irq_dispatch
// Purpose  : Filters the c432 priority encoder output, captures a 6-bit vector
//            and drives an IRQ/ACK handshake with ACK timeout and cooldown.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module c432_irq_dispatch #(
    parameter int STABLE  = 2,
    parameter int TIMEOUT = 16,
    parameter int COOL    = 4
) (
    input  logic       CK,
    input  logic       RST,
    input  logic       PA,
    input  logic       PB,
    input  logic       PC,
    input  logic [3:0] CHAN,
    input  logic       ACK,
    output logic       IRQ,
    output logic [5:0] VEC,
    output logic       BUSY,
    output logic       TO,
    output logic [7:0] TO_CNT
);

    localparam logic [3:0] c_stable    = 4'(STABLE);
    localparam logic [7:0] c_tcnt_last = 8'(TIMEOUT - 1);
    localparam logic [7:0] c_ccnt_last = 8'(COOL - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ASSERT = 2'd1,
        COOLDN = 2'd2
    } state_t;

    state_t     r_state, w_state_nxt;
    logic [3:0] r_cnt,   w_cnt_nxt;
    logic [5:0] r_prev,  w_prev_nxt;
    logic [7:0] r_tcnt,  w_tcnt_nxt;
    logic [7:0] r_ccnt,  w_ccnt_nxt;
    logic       r_irq,   w_irq_nxt;
    logic [5:0] r_vec,   w_vec_nxt;
    logic       r_to,    w_to_nxt;
    logic [7:0] r_to_cnt, w_to_cnt_nxt;

    logic [1:0] w_bus;
    logic [5:0] w_cur;
    logic [3:0] w_cnt_new;

    // Bus A outranks B outranks C, mirroring the encoder's grant order.
    always_comb begin
        if (PA)      w_bus = 2'd1;
        else if (PB) w_bus = 2'd2;
        else if (PC) w_bus = 2'd3;
        else         w_bus = 2'd0;
    end

    assign w_cur = {w_bus, CHAN};

    always_comb begin
        if (w_bus == 2'd0)
            w_cnt_new = 4'd0;
        else if (w_cur == r_prev && r_cnt != 4'd0)
            w_cnt_new = r_cnt + 4'd1;
        else
            w_cnt_new = 4'd1;
    end

    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            r_state  <= IDLE;
            r_cnt    <= 4'd0;
            r_prev   <= 6'd0;
            r_tcnt   <= 8'd0;
            r_ccnt   <= 8'd0;
            r_irq    <= 1'b0;
            r_vec    <= 6'd0;
            r_to     <= 1'b0;
            r_to_cnt <= 8'd0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_prev   <= w_prev_nxt;
            r_tcnt   <= w_tcnt_nxt;
            r_ccnt   <= w_ccnt_nxt;
            r_irq    <= w_irq_nxt;
            r_vec    <= w_vec_nxt;
            r_to     <= w_to_nxt;
            r_to_cnt <= w_to_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_prev_nxt   = r_prev;
        w_tcnt_nxt   = r_tcnt;
        w_ccnt_nxt   = r_ccnt;
        w_irq_nxt    = r_irq;
        w_vec_nxt    = r_vec;
        w_to_nxt     = 1'b0;
        w_to_cnt_nxt = r_to_cnt;

        case (r_state)
            IDLE: begin
                w_prev_nxt = w_cur;
                w_cnt_nxt  = w_cnt_new;
                if (w_cnt_new == c_stable) begin
                    w_vec_nxt   = w_cur;
                    w_irq_nxt   = 1'b1;
                    w_tcnt_nxt  = 8'd0;
                    w_cnt_nxt   = 4'd0;
                    w_state_nxt = ASSERT;
                end
            end
            ASSERT: begin
                w_tcnt_nxt = r_tcnt + 8'd1;
                // ACK takes precedence over a timeout landing on the same edge.
                if (ACK) begin
                    w_irq_nxt   = 1'b0;
                    w_ccnt_nxt  = 8'd0;
                    w_state_nxt = COOLDN;
                end else if (r_tcnt == c_tcnt_last) begin
                    w_irq_nxt   = 1'b0;
                    w_to_nxt    = 1'b1;
                    w_ccnt_nxt  = 8'd0;
                    w_state_nxt = COOLDN;
                    if (r_to_cnt != 8'hFF)
                        w_to_cnt_nxt = r_to_cnt + 8'd1;
                end
            end
            COOLDN: begin
                w_ccnt_nxt = r_ccnt + 8'd1;
                // Clearing prev forces a held request to requalify from scratch.
                if (r_ccnt == c_ccnt_last) begin
                    w_cnt_nxt   = 4'd0;
                    w_prev_nxt  = 6'd0;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign IRQ    = r_irq;
    assign VEC    = r_vec;
    assign TO     = r_to;
    assign TO_CNT = r_to_cnt;
    assign BUSY   = (r_state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_c432_irq_dispatch.sv
// ============================================================================
// Module   : tb_c432_irq_dispatch
// Purpose  : Directed self-checking bench for c432_irq_dispatch (defaults).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_c432_irq_dispatch;

    logic       CK;
    logic       RST;
    logic       PA, PB, PC;
    logic [3:0] CHAN;
    logic       ACK;
    logic       IRQ;
    logic [5:0] VEC;
    logic       BUSY;
    logic       TO;
    logic [7:0] TO_CNT;

    int n_checks = 0;
    int n_errors = 0;

    c432_irq_dispatch #(.STABLE(2), .TIMEOUT(16), .COOL(4)) u_dut (
        .CK     (CK),
        .RST    (RST),
        .PA     (PA),
        .PB     (PB),
        .PC     (PC),
        .CHAN   (CHAN),
        .ACK    (ACK),
        .IRQ    (IRQ),
        .VEC    (VEC),
        .BUSY   (BUSY),
        .TO     (TO),
        .TO_CNT (TO_CNT)
    );

    initial CK = 1'b0;
    always #5 CK = ~CK;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CK);
        #1;
    endtask

    task automatic req(input logic a, input logic b, input logic c, input logic [3:0] ch);
        PA = a; PB = b; PC = c; CHAN = ch;
    endtask

    int ones;
    int pulses;
    int budget;

    initial begin
        RST = 1'b1; ACK = 1'b0;
        req(0, 0, 0, 4'h0);
        repeat (2) @(posedge CK);
        #1 RST = 1'b0;
        check("rst_irq", IRQ, 0);
        check("rst_vec", VEC, 0);
        check("rst_busy", BUSY, 0);
        check("rst_tocnt", TO_CNT, 0);
        check("rst_to", TO, 0);

        // Idle inputs for 20 cycles
        ones = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (IRQ || BUSY || VEC != 0 || TO_CNT != 0) ones++;
        end
        check("idle_quiet", ones, 0);

        // Capture on bus B, ACK on the third IRQ cycle
        req(0, 1, 0, 4'h5);
        tick();
        check("capB_edge1_irq", IRQ, 0);
        tick();
        check("capB_irq", IRQ, 1);
        check("capB_vec", VEC, 6'h25);
        check("capB_busy", BUSY, 1);
        tick();
        tick();
        check("capB_irq3", IRQ, 1);
        ACK = 1'b1; req(0, 0, 0, 4'h0);
        tick();
        ACK = 1'b0;
        check("ack_irq", IRQ, 0);
        check("ack_to", TO, 0);
        ones = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (BUSY) ones++;
        end
        check("cool_busy_cycles", ones + 1, 4);
        tick();
        check("cool_done_busy", BUSY, 0);
        check("cool_vec_hold", VEC, 6'h25);

        // Unstable CHAN on bus A, then held
        ones = 0;
        for (int i = 0; i < 8; i++) begin
            req(1, 0, 0, (i % 2 == 1) ? 4'h3 : 4'h4);
            tick();
            if (IRQ) ones++;
        end
        check("unstable_no_irq", ones, 0);
        req(1, 0, 0, 4'h4);
        tick();
        check("stable_edge1_irq", IRQ, 0);
        tick();
        check("stable_irq", IRQ, 1);
        check("stable_vec", VEC, 6'h14);
        ACK = 1'b1; req(0, 0, 0, 4'h0);
        tick();
        ACK = 1'b0;
        repeat (4) tick();
        check("stable_idle", BUSY, 0);

        // Timeout on bus C
        req(0, 0, 1, 4'h8);
        tick();
        tick();
        check("to_cap_irq", IRQ, 1);
        check("to_cap_vec", VEC, 6'h38);
        ones = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (IRQ && !TO) ones++;
        end
        check("to_irq_hold", ones, 15);
        tick();
        check("to_irq_drop", IRQ, 0);
        check("to_pulse", TO, 1);
        check("to_cnt1", TO_CNT, 1);
        check("to_busy", BUSY, 1);
        tick();
        check("to_pulse_end", TO, 0);
        ones = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (IRQ) ones++;
        end
        check("to_requal_wait", ones, 0);
        tick();
        check("to_recap_irq", IRQ, 1);
        check("to_recap_vec", VEC, 6'h38);
        ACK = 1'b1; req(0, 0, 0, 4'h0);
        tick();
        ACK = 1'b0;
        repeat (4) tick();
        check("to_idle", BUSY, 0);

        // ACK arrives on the same edge the timeout would fire
        req(1, 0, 0, 4'h2);
        tick();
        tick();
        check("col_vec", VEC, 6'h12);
        repeat (15) tick();
        check("col_irq_before", IRQ, 1);
        ACK = 1'b1;
        tick();
        ACK = 1'b0;
        check("col_irq", IRQ, 0);
        check("col_to", TO, 0);
        check("col_tocnt", TO_CNT, 1);
        repeat (4) tick();
        check("col_idle", BUSY, 0);

        // Saturation: 260 forced timeouts with request held
        pulses = 0;
        budget = 260 * 22 + 200;
        while (pulses < 260 && budget > 0) begin
            tick();
            budget--;
            if (TO) pulses++;
        end
        check("sat_pulses", pulses, 260);
        check("sat_tocnt", TO_CNT, 255);
        req(0, 0, 0, 4'h0);
        repeat (6) tick();
        check("sat_idle", BUSY, 0);

        // Asynchronous reset while IRQ is high
        req(0, 1, 0, 4'h7);
        tick();
        tick();
        check("ar_irq_pre", IRQ, 1);
        check("ar_vec_pre", VEC, 6'h27);
        #2 RST = 1'b1;
        #1;
        check("ar_irq", IRQ, 0);
        check("ar_vec", VEC, 0);
        check("ar_busy", BUSY, 0);
        check("ar_tocnt", TO_CNT, 0);
        #2 RST = 1'b0;
        tick();
        check("ar_edge1_irq", IRQ, 0);
        check("ar_edge1_to", TO, 0);
        tick();
        check("ar_recap_irq", IRQ, 1);
        check("ar_recap_vec", VEC, 6'h27);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
